// File: rtl/trap_ctrl.sv
// Write-back trap consumer: flushes the pipeline and hands one redirect PC to fetch per trap, MRET or boot.
// Optional vectored interrupt targets are enabled by defining TRAP_CTRL_VECTORED_EN.
module trap_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h8000_0000,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_valid_i,
    input  logic [31:0] wb_pc_i,
    input  logic        exc_taken_i,
    input  logic        mret_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        mstatus_mie_i,
    input  logic [2:0]  mie_i,
    input  logic        xint_meip_i,
    input  logic        xint_mtip_i,
    input  logic        xint_msip_i,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        int_taken_o,
    output logic [31:0] int_cause_o,
    output logic [31:0] int_epc_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT
    } state_t;

    localparam logic [2:0]  FLUSH_LD   = 3'(FLUSH_CYCLES);
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        r_flush, w_flush_nxt;
    logic        r_rvalid, w_rvalid_nxt;
    logic [31:0] r_rpc, w_rpc_nxt;
    logic        r_itk, w_itk_nxt;
    logic [31:0] r_cause, w_cause_nxt;
    logic [31:0] r_epc, w_epc_nxt;

    logic [2:0]  w_pend;
    logic        w_int_req;
    logic [3:0]  w_code;
    logic [31:0] w_base;
    logic [31:0] w_int_tgt;

    assign w_pend    = {xint_meip_i, xint_mtip_i, xint_msip_i} & mie_i;
    assign w_int_req = wb_valid_i & mstatus_mie_i & (|w_pend);
    assign w_base    = mtvec_i & ALIGN_MASK;

    // Code priority is MEI > MSI > MTI, which is not the bit order of mie_i.
    always_comb begin
        w_code = 4'd7;
        if (w_pend[2]) begin
            w_code = 4'd11;
        end else if (w_pend[0]) begin
            w_code = 4'd3;
        end
    end

`ifdef TRAP_CTRL_VECTORED_EN
    assign w_int_tgt = (mtvec_i[1:0] == 2'b01) ? (w_base + {26'b0, w_code, 2'b00}) : w_base;
`else
    assign w_int_tgt = w_base;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_flush_nxt  = r_flush;
        w_rvalid_nxt = r_rvalid;
        w_rpc_nxt    = r_rpc;
        w_itk_nxt    = 1'b0;
        w_cause_nxt  = r_cause;
        w_epc_nxt    = r_epc;
        case (r_state)
            ST_BOOT: begin
                w_rvalid_nxt = 1'b1;
                w_rpc_nxt    = RESET_PC;
                w_state_nxt  = ST_REDIRECT;
            end
            ST_IDLE: begin
                if (exc_taken_i || mret_i || w_int_req) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = FLUSH_LD;
                    w_flush_nxt = 1'b1;
                end
                if (exc_taken_i) begin
                    w_rpc_nxt = w_base;
                end else if (mret_i) begin
                    w_rpc_nxt = mepc_i & ALIGN_MASK;
                end else if (w_int_req) begin
                    w_rpc_nxt   = w_int_tgt;
                    w_itk_nxt   = 1'b1;
                    w_cause_nxt = {1'b1, 27'b0, w_code};
                    w_epc_nxt   = wb_pc_i + 32'd4;
                end
            end
            ST_FLUSH: begin
                if (r_cnt <= 3'd1) begin
                    w_cnt_nxt    = 3'd0;
                    w_flush_nxt  = 1'b0;
                    w_rvalid_nxt = 1'b1;
                    w_state_nxt  = ST_REDIRECT;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready_i) begin
                    w_rvalid_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_BOOT;
            r_cnt    <= 3'd0;
            r_flush  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rpc    <= RESET_PC;
            r_itk    <= 1'b0;
            r_cause  <= 32'd0;
            r_epc    <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_flush  <= w_flush_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_rpc    <= w_rpc_nxt;
            r_itk    <= w_itk_nxt;
            r_cause  <= w_cause_nxt;
            r_epc    <= w_epc_nxt;
        end
    end

    assign flush_o          = r_flush;
    assign redirect_valid_o = r_rvalid;
    assign redirect_pc_o    = r_rpc;
    assign int_taken_o      = r_itk;
    assign int_cause_o      = r_cause;
    assign int_epc_o        = r_epc;
    assign busy_o           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: two instances (1 and 3 flush cycles) against a transaction-level reference model.
module tb_trap_ctrl;

    localparam logic [31:0] RPC = 32'h8000_0000;
`ifdef TRAP_CTRL_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wbv = 1'b0, exc = 1'b0, mret = 1'b0, mstie = 1'b0;
    logic [2:0]  mie = 3'b0;
    logic        meip = 1'b0, mtip = 1'b0, msip = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] wbpc = 32'd0, mtvec = 32'd0, mepc = 32'd0;

    logic        f1, v1, itk1, busy1, f3, v3, itk3, busy3;
    logic [31:0] pc1, cause1, epc1, pc3, cause3, epc3;

    always #5 clk = ~clk;

    trap_ctrl #(.RESET_PC(RPC), .FLUSH_CYCLES(1)) u_d1 (
        .clk_i(clk), .rst_i(rst), .wb_valid_i(wbv), .wb_pc_i(wbpc), .exc_taken_i(exc),
        .mret_i(mret), .mtvec_i(mtvec), .mepc_i(mepc), .mstatus_mie_i(mstie), .mie_i(mie),
        .xint_meip_i(meip), .xint_mtip_i(mtip), .xint_msip_i(msip), .flush_o(f1),
        .redirect_valid_o(v1), .redirect_pc_o(pc1), .redirect_ready_i(ready),
        .int_taken_o(itk1), .int_cause_o(cause1), .int_epc_o(epc1), .busy_o(busy1));

    trap_ctrl #(.RESET_PC(RPC), .FLUSH_CYCLES(3)) u_d3 (
        .clk_i(clk), .rst_i(rst), .wb_valid_i(wbv), .wb_pc_i(wbpc), .exc_taken_i(exc),
        .mret_i(mret), .mtvec_i(mtvec), .mepc_i(mepc), .mstatus_mie_i(mstie), .mie_i(mie),
        .xint_meip_i(meip), .xint_mtip_i(mtip), .xint_msip_i(msip), .flush_o(f3),
        .redirect_valid_o(v3), .redirect_pc_o(pc3), .redirect_ready_i(ready),
        .int_taken_o(itk3), .int_cause_o(cause3), .int_epc_o(epc3), .busy_o(busy3));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks pending flush cycles and an outstanding offer to fetch.
    typedef struct {
        int          flush_cycles;
        bit          booting;
        int          flush_left;
        bit          offering;
        logic [31:0] pc;
        bit          itk;
        logic [31:0] cause;
        logic [31:0] epc;
    } mdl_t;

    function automatic mdl_t mreset(input int fc);
        mdl_t m;
        m.flush_cycles = fc;
        m.booting      = 1'b1;
        m.flush_left   = 0;
        m.offering     = 1'b0;
        m.pc           = RPC;
        m.itk          = 1'b0;
        m.cause        = 32'd0;
        m.epc          = 32'd0;
        return m;
    endfunction

    function automatic mdl_t mstep(input mdl_t m_in);
        mdl_t        m;
        logic [2:0]  act;
        logic [31:0] base;
        logic [1:0]  mode;
        int          code;
        m    = m_in;
        m.itk = 1'b0;
        act  = {meip, mtip, msip} & mie;
        base = mtvec & 32'hFFFF_FFFC;
        mode = mtvec[1:0];
        if (m.booting) begin
            m.booting  = 1'b0;
            m.offering = 1'b1;
            m.pc       = RPC;
        end else if (m.flush_left > 0) begin
            m.flush_left--;
            if (m.flush_left == 0) m.offering = 1'b1;
        end else if (m.offering) begin
            if (ready) m.offering = 1'b0;
        end else if (exc) begin
            m.pc = base;
            m.flush_left = m.flush_cycles;
        end else if (mret) begin
            m.pc = mepc & 32'hFFFF_FFFC;
            m.flush_left = m.flush_cycles;
        end else if (wbv && mstie && act != 3'b000) begin
            code    = act[2] ? 11 : (act[0] ? 3 : 7);
            m.itk   = 1'b1;
            m.cause = 32'h8000_0000 + 32'(code);
            m.epc   = wbpc + 32'd4;
            m.pc    = (VEC && mode == 2'b01) ? base + 32'(code * 4) : base;
            m.flush_left = m.flush_cycles;
        end
        return m;
    endfunction

    mdl_t m1, m3;
    bit   chk_en = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 = mreset(1);
            m3 = mreset(3);
        end else begin
            m1 = mstep(m1);
            m3 = mstep(m3);
        end
    end

    task automatic cmp_dut(input string tag, input mdl_t m, input logic f, input logic v,
                           input logic [31:0] pc, input logic itk, input logic [31:0] cause,
                           input logic [31:0] epc, input logic busy);
        chk({tag, "_flush"}, 32'(f), 32'(m.flush_left > 0));
        chk({tag, "_valid"}, 32'(v), 32'(m.offering));
        chk({tag, "_pc"}, pc, m.pc);
        chk({tag, "_itk"}, 32'(itk), 32'(m.itk));
        chk({tag, "_cause"}, cause, m.cause);
        chk({tag, "_epc"}, epc, m.epc);
        chk({tag, "_busy"}, 32'(busy), 32'(m.booting || m.flush_left > 0 || m.offering));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut("d1", m1, f1, v1, pc1, itk1, cause1, epc1, busy1);
            cmp_dut("d3", m3, f3, v3, pc3, itk3, cause3, epc3, busy3);
        end
    end

    typedef struct {
        logic        exc, mret, wbv, mstie;
        logic [2:0]  mie, pend;
        logic [31:0] mtvec, mepc, wbpc;
        bit          evt;
        logic [31:0] exp_pc;
        logic        exp_itk;
        logic [31:0] exp_cause, exp_epc;
    } vec_t;

    function automatic vec_t mkv(input logic e, input logic r, input logic w, input logic s,
                                 input logic [2:0] en, input logic [2:0] pd, input logic [31:0] tv,
                                 input logic [31:0] ep, input logic [31:0] wp, input bit ev,
                                 input logic [31:0] xpc, input logic xi, input logic [31:0] xc,
                                 input logic [31:0] xe);
        vec_t t;
        t.exc = e; t.mret = r; t.wbv = w; t.mstie = s; t.mie = en; t.pend = pd;
        t.mtvec = tv; t.mepc = ep; t.wbpc = wp; t.evt = ev; t.exp_pc = xpc;
        t.exp_itk = xi; t.exp_cause = xc; t.exp_epc = xe;
        return t;
    endfunction

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy1 || busy3) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", 32'(busy1 | busy3), 32'd0);
    endtask

    task automatic clear_events();
        exc = 1'b0; mret = 1'b0; wbv = 1'b0;
        {meip, mtip, msip} = 3'b000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        int   nf, nv;
        logic [31:0] pc0;

        tbl[0] = mkv(1, 0, 0, 0, 3'b000, 3'b000, 32'h0000_0101, 32'h0, 32'h0, 1, 32'h0000_0100, 0, 0, 0);
        tbl[1] = mkv(0, 1, 0, 0, 3'b000, 3'b000, 32'h0, 32'h8000_0456, 32'h0, 1, 32'h8000_0454, 0, 0, 0);
        tbl[2] = mkv(0, 0, 1, 1, 3'b111, 3'b111, 32'h0000_0201, 32'h0, 32'h0000_0100, 1,
                     VEC ? 32'h0000_022C : 32'h0000_0200, 1, 32'h8000_000B, 32'h0000_0104);
        tbl[3] = mkv(1, 0, 1, 1, 3'b111, 3'b100, 32'h0000_0201, 32'h0, 32'h0000_0100, 1, 32'h0000_0200, 0, 0, 0);
        tbl[4] = mkv(0, 1, 1, 1, 3'b111, 3'b100, 32'h0000_0201, 32'h0000_1238, 32'h0, 1, 32'h0000_1238, 0, 0, 0);
        tbl[5] = mkv(0, 0, 1, 1, 3'b111, 3'b011, 32'h0000_0301, 32'h0, 32'hFFFF_FFFC, 1,
                     VEC ? 32'h0000_030C : 32'h0000_0300, 1, 32'h8000_0003, 32'h0000_0000);
        tbl[6] = mkv(0, 0, 1, 1, 3'b111, 3'b010, 32'hFFFF_FFFD, 32'h0, 32'h0000_0040, 1,
                     VEC ? 32'h0000_0018 : 32'hFFFF_FFFC, 1, 32'h8000_0007, 32'h0000_0044);
        tbl[7] = mkv(0, 0, 1, 0, 3'b111, 3'b111, 32'h0000_0500, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        tbl[8] = mkv(0, 0, 1, 1, 3'b011, 3'b100, 32'h0000_0500, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        tbl[9] = mkv(0, 0, 0, 1, 3'b111, 3'b111, 32'h0000_0500, 32'h0, 32'h0, 0, 0, 0, 0, 0);

        // Reset values
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_valid", 32'(v1), 32'd0);
        chk("rst_pc", pc1, RPC);
        chk("rst_flush", 32'(f1), 32'd0);
        chk("rst_itk", 32'(itk1), 32'd0);
        chk("rst_cause", cause1, 32'd0);
        chk("rst_epc", epc1, 32'd0);

        // Boot redirect, accepted on the second edge
        ready = 1'b1;
        rst   = 1'b0;
        @(negedge clk);
        chk("boot_valid", 32'(v1), 32'd1);
        chk("boot_pc", pc1, RPC);
        chk("boot_flush", 32'(f1), 32'd0);
        @(negedge clk);
        chk("boot_drop", 32'(v1), 32'd0);
        chk("boot_flush2", 32'(f1), 32'd0);
        chk("boot_busy", 32'(busy1), 32'd0);

        // Single events from IDLE
        for (int i = 0; i < 10; i++) begin
            wait_idle(20);
            @(negedge clk);
            exc = tbl[i].exc; mret = tbl[i].mret; wbv = tbl[i].wbv; mstie = tbl[i].mstie;
            mie = tbl[i].mie; {meip, mtip, msip} = tbl[i].pend;
            mtvec = tbl[i].mtvec; mepc = tbl[i].mepc; wbpc = tbl[i].wbpc;
            @(negedge clk);
            clear_events();
            chk("tbl_itk", 32'(itk1), 32'(tbl[i].exp_itk));
            if (tbl[i].exp_itk) begin
                chk("tbl_cause", cause1, tbl[i].exp_cause);
                chk("tbl_epc", epc1, tbl[i].exp_epc);
            end
            if (tbl[i].evt) begin
                chk("tbl_flush", 32'(f1), 32'd1);
                for (int k = 0; k < 10 && !v1; k++) @(negedge clk);
                chk("tbl_valid", 32'(v1), 32'd1);
                chk("tbl_pc", pc1, tbl[i].exp_pc);
            end else begin
                chk("tbl_no_event", 32'(busy1), 32'd0);
            end
        end

        // Three flush cycles, fetch stalls five cycles, exception pulse ignored
        wait_idle(20);
        @(negedge clk);
        ready = 1'b0;
        exc   = 1'b1;
        mtvec = 32'h0000_0403;
        @(negedge clk);
        exc = 1'b0;
        nf  = 0;
        nv  = 0;
        pc0 = 32'd0;
        for (int k = 0; k < 30; k++) begin
            if (f3) nf++;
            if (v3) begin
                if (nv == 0) pc0 = pc3;
                else chk("f3_pc_hold", pc3, pc0);
                nv++;
            end
            exc = (k == 1);
            if (nv >= 5) ready = 1'b1;
            @(negedge clk);
        end
        chk("f3_flush_cycles", 32'(nf), 32'd3);
        chk("f3_valid_cycles", 32'(nv), 32'd5);
        chk("f3_pc", pc0, 32'h0000_0400);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            exc   = ($urandom_range(7) == 0);
            mret  = ($urandom_range(7) == 0);
            wbv   = $urandom_range(1) == 1;
            mstie = ($urandom_range(3) != 0);
            mie   = 3'($urandom);
            {meip, mtip, msip} = 3'($urandom);
            mtvec = $urandom;
            if ($urandom_range(1) == 1) mtvec[1:0] = 2'b01;
            mepc  = $urandom;
            wbpc  = $urandom;
            ready = ($urandom_range(1) == 1);
        end
        @(negedge clk);
        clear_events();
        ready = 1'b1;
        wait_idle(20);

        // Reset asserted while a redirect is being offered
        @(negedge clk);
        ready = 1'b0;
        exc   = 1'b1;
        mtvec = 32'h0000_0404;
        @(negedge clk);
        exc = 1'b0;
        @(negedge clk);
        chk("mid_pre_valid", 32'(v1), 32'd1);
        chk("mid_pre_pc", pc1, 32'h0000_0404);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(v1), 32'd0);
        chk("mid_rst_flush", 32'(f1), 32'd0);
        chk("mid_rst_pc", pc1, RPC);
        chk("mid_rst_itk", 32'(itk1), 32'd0);
        @(negedge clk);
        ready = 1'b1;
        rst   = 1'b0;
        @(negedge clk);
        chk("reboot_valid", 32'(v1), 32'd1);
        chk("reboot_pc", pc1, RPC);
        @(negedge clk);
        chk("reboot_drop", 32'(v1), 32'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Consumer side of the write-back stage's trap signalling.
- Takes the synchronous-exception flag, MRET retirement and the machine interrupt lines (meip/mtip/msip) at the write-back boundary.
- Flushes the pipeline, then hands a single redirect PC to fetch over a valid/ready handshake: trap vector, mepc, or the reset PC at boot.
- Also raises the interrupt-trap request that the CSR file uses to latch mcause/mepc.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset release.
- FLUSH_CYCLES, 1, cycles flush_o is held per trap/return; legal range 1..4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- wb_valid_i  in  1  an instruction retires in WB this cycle
- wb_pc_i  in  32  PC of the retiring instruction
- exc_taken_i  in  1  synchronous exception taken in WB
- mret_i  in  1  MRET retiring in WB
- mtvec_i  in  32  current mtvec
- mepc_i  in  32  current mepc
- mstatus_mie_i  in  1  global machine interrupt enable
- mie_i  in  3  {meie, mtie, msie}
- xint_meip_i / xint_mtip_i / xint_msip_i  in  1 each  pending lines
- flush_o  out  1  kill all in-flight instructions
- redirect_valid_o  out  1  redirect PC offered to fetch
- redirect_pc_o  out  32  target PC
- redirect_ready_i  in  1  fetch accepts the redirect
- int_taken_o  out  1  one-cycle pulse; CSR latches int_cause_o and int_epc_o
- int_cause_o  out  32  {1'b1, 27'b0, code}
- int_epc_o  out  32  PC to save for the interrupt
- busy_o  out  1  state != IDLE

Behaviour:
- States: BOOT, IDLE, FLUSH, REDIRECT.
- Reset (async): state=BOOT, flush cnt=0, all outputs 0, redirect_pc_o=RESET_PC.
- BOOT:
  - First clock edge after release sets redirect_valid_o=1 with RESET_PC and moves to REDIRECT.
  - No flush is issued at boot.
- IDLE: events sampled every cycle, priority exc_taken_i > mret_i > interrupt.
  - Exception target: mtvec_i & ~3.
  - MRET target: mepc_i & ~3.
  - Interrupt condition: wb_valid_i & mstatus_mie_i & |(pending & enable). Code priority MEI=11 > MSI=3 > MTI=7.
  - Interrupt epc: wb_pc_i + 4; the retiring instruction completes.
  - Interrupt outputs: int_taken_o pulses, int_cause_o and int_epc_o are registered.
  - Interrupt target: mtvec base, or base + 4*code in vectored mode (see Optional Feature).
- Timing: event sampled at edge N.
  - Edge N registers redirect_pc_o, loads the counter with FLUSH_CYCLES and enters FLUSH.
  - flush_o is high from cycle N+1 for exactly FLUSH_CYCLES cycles.
  - Then REDIRECT with redirect_valid_o=1.
- REDIRECT:
  - redirect_valid_o and redirect_pc_o are held stable until redirect_ready_i=1 at an edge.
  - At that edge: valid drops to 0, return to IDLE. Earliest next event is sampled the cycle after.
- Busy: in FLUSH/REDIRECT/BOOT, exc_taken_i, mret_i and interrupts are ignored (instructions are being flushed); nothing is queued.
- int_cause_o / int_epc_o hold their value until the next interrupt.
- Widths:
  - Vector add is 32-bit modulo; carry dropped, wrap allowed.
  - The counter is 3 bits.
- Simultaneous events: exc_taken_i with an interrupt → exception only, int_taken_o stays 0. mret_i with an interrupt → MRET only.
- Interrupt sampling: pending lines are level-sampled; a line deasserted before IDLE sampling is not taken.

Optional Feature:
- TRAP_CTRL_VECTORED_EN defined:
  - mtvec_i[1:0]==2'b01 selects vectored mode; interrupt target = (mtvec_i & ~3) + (code << 2).
  - Exceptions always use the base.
- Undefined: mtvec_i[1:0] is ignored; all traps go to mtvec_i & ~3.

Test Plan:
- Reset release, RESET_PC default, redirect_ready_i=1 one cycle later → redirect_valid_o=1 with 0x8000_0000 for one cycle, flush_o never high, then IDLE/busy_o=0.
- exc_taken_i=1, mtvec_i=0x0000_0101 → flush_o high 1 cycle; redirect 0x0000_0100; int_taken_o=0.
- mret_i=1, mepc_i=0x8000_0456 → redirect_pc_o=0x8000_0454 after 1 flush cycle.
- FLUSH_CYCLES=3, redirect_ready_i low for 5 cycles:
  - flush_o high exactly 3 cycles.
  - redirect_valid_o held 5 cycles with constant PC.
  - An exc_taken_i pulse during this window is ignored.
- mstatus_mie_i=1, mie_i=3'b111, all pending, wb_valid_i=1, wb_pc_i=0x100, mtvec_i=0x201:
  - int_cause_o=0x8000_000B, int_epc_o=0x104, int_taken_o one cycle.
  - Redirect 0x22C with TRAP_CTRL_VECTORED_EN, 0x200 without.
- Same cycle exc_taken_i=1 and meip pending with enables → exception path only, int_taken_o=0.
- Assert rst_i mid-REDIRECT → outputs 0 immediately; after release, reboot redirect to RESET_PC.
